// File: rtl/error_pkg.sv
// Shared types for the error logger: queued entry layout and lookup states.
// Default widths match the logger's parameter defaults.
package error_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_ERR_W  = 10;
   localparam int DEF_DEPTH  = 4;
   localparam int CNT_W      = 16;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] address;
      logic [DEF_ERR_W-1:0]  error;
   } err_entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } lkp_state_e;

   // Saturating increment used by the event counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/error_fifo.sv
// Registered circular FIFO of error entries; head is visible combinationally.
// Push is refused when full, even if a pop happens in the same cycle.
module error_fifo
   import error_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  err_entry_t                 din,
   output err_entry_t                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   err_entry_t        mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents are don't-care while their slot is unoccupied.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy tracks pushes minus pops; simultaneous ones cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/error_logger.sv
// Queues pipeline error events into error_ram and serves address lookups.
// Lookups start only once every earlier event has reached the RAM.
module error_logger
   import error_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_DEPTH,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int ERR_W      = DEF_ERR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evt_valid,
   output logic              evt_ready,
   input  logic [ADDR_W-1:0] evt_address,
   input  logic [ERR_W-1:0]  evt_error,
   input  logic              lkp_valid,
   output logic              lkp_ready,
   input  logic [ADDR_W-1:0] lkp_address,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ERR_W-1:0]  rsp_error,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_address,
   output logic [ERR_W-1:0]  write_error,
   output logic              read_enable,
   output logic [ADDR_W-1:0] read_address,
   input  logic [ERR_W-1:0]  read_error,
   output logic [15:0]       evt_count
);

   localparam int OW = $clog2(FIFO_DEPTH) + 1;

   err_entry_t   in_entry;
   err_entry_t   head;
   err_entry_t   last;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic [OW-1:0] occ;
   logic         lkp_fire;
   lkp_state_e   state;
   lkp_state_e   state_nxt;

   assign in_entry.address = evt_address;
   assign in_entry.error   = evt_error;
   assign evt_ready        = !full;
   assign push             = evt_valid && evt_ready;
   assign pop              = !empty;

   error_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (in_entry),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (occ)
   );

   // Remember the last committed entry so the write bus holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= '0;
      end else if (pop) begin
         last <= head;
      end
   end

   // Write port follows the FIFO head directly: one write per cycle.
   always_comb begin
      write_enable  = pop;
      write_address = pop ? head.address : last.address;
      write_error   = pop ? head.error   : last.error;
   end

   // Count committed writes, holding at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_count <= '0;
      end else if (write_enable) begin
         evt_count <= sat_inc(evt_count);
      end
   end

   assign lkp_fire = lkp_valid && lkp_ready;

   // Lookup state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Lookup next-state: one read cycle, one capture cycle, then respond.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (lkp_fire) state_nxt = READ;
         READ:    state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lookup outputs decoded from the current state.
   always_comb begin
      lkp_ready   = 1'b0;
      read_enable = 1'b0;
      rsp_valid   = 1'b0;
      unique case (state)
         IDLE:    lkp_ready   = (occ == '0);
         READ:    read_enable = 1'b1;
         CAPTURE: ;
         RESP:    rsp_valid   = 1'b1;
         default: ;
      endcase
   end

   // Latch the lookup address at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_address <= '0;
      end else if (lkp_fire) begin
         read_address <= lkp_address;
      end
   end

   // Capture RAM read data one cycle after the read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_error <= '0;
      end else if (state == CAPTURE) begin
         rsp_error <= read_error;
      end
   end

endmodule

// File: tb/tb_error_logger.sv
// Randomized bench for error_logger with a queue/map reference model.
// Includes a behavioural error_ram with one-cycle read latency.
module tb_error_logger;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int EW    = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          evt_valid = 1'b0;
   logic          evt_ready;
   logic [AW-1:0] evt_address = '0;
   logic [EW-1:0] evt_error = '0;
   logic          lkp_valid = 1'b0;
   logic          lkp_ready;
   logic [AW-1:0] lkp_address = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [EW-1:0] rsp_error;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [EW-1:0] write_error;
   logic          read_enable;
   logic [AW-1:0] read_address;
   logic [EW-1:0] read_error = '0;
   logic [15:0]   evt_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   error_logger #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (AW),
      .ERR_W      (EW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_address   (evt_address),
      .evt_error     (evt_error),
      .lkp_valid     (lkp_valid),
      .lkp_ready     (lkp_ready),
      .lkp_address   (lkp_address),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_error     (rsp_error),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_error   (write_error),
      .read_enable   (read_enable),
      .read_address  (read_address),
      .read_error    (read_error),
      .evt_count     (evt_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Environment RAM: read returns pre-write contents, unwritten reads 0.
   logic [EW-1:0] ram [bit [31:0]];
   always @(posedge clk) begin
      if (read_enable)
         read_error <= ram.exists(read_address) ? ram[read_address] : '0;
      if (write_enable)
         ram[write_address] = write_error;
   end

   // Reference model state.
   typedef struct {
      logic [AW-1:0] a;
      logic [EW-1:0] e;
      int            c;
   } ev_t;

   ev_t           q[$];
   logic [EW-1:0] mref [bit [31:0]];
   int            cyc = 0;
   bit            pend = 0;
   int            acc = 0;
   logic [AW-1:0] laddr;
   logic [EW-1:0] lexp;
   int            wcnt = 0;
   bit            lkp_hs = 0;

   // Model: queued events drain one per cycle starting the cycle after
   // acceptance; lookups see the map of writes committed so far.
   always @(negedge clk) begin
      bit exp_er;
      bit exp_lr;
      cyc++;
      lkp_hs = 0;
      if (!rst_n) begin
         q.delete();
         pend = 0;
         wcnt = 0;
      end else begin
         exp_er = (q.size() < DEPTH);
         exp_lr = !pend && (q.size() == 0);
         chk("evt_ready", evt_ready, exp_er);
         chk("lkp_ready", lkp_ready, exp_lr);
         chk("evt_count", evt_count, (wcnt > 65535) ? 65535 : wcnt);
         if (q.size() > 0) begin
            chk("we", write_enable, 1);
            chk("waddr", write_address, q[0].a);
            chk("werr", write_error, q[0].e);
            mref[q[0].a] = q[0].e;
            void'(q.pop_front());
            wcnt++;
         end else begin
            chk("we_idle", write_enable, 0);
         end
         if (pend) begin
            chk("re", read_enable, cyc == acc + 1);
            if (cyc == acc + 1) chk("raddr", read_address, laddr);
            chk("rv", rsp_valid, cyc >= acc + 3);
            if (cyc >= acc + 3) begin
               chk("rerr", rsp_error, lexp);
               if (rsp_ready) pend = 0;
            end
         end else begin
            chk("re_idle", read_enable, 0);
            chk("rv_idle", rsp_valid, 0);
         end
         if (lkp_valid && exp_lr) begin
            pend  = 1;
            acc   = cyc;
            laddr = lkp_address;
            lexp  = mref.exists(lkp_address) ? mref[lkp_address] : '0;
            lkp_hs = 1;
         end
         if (evt_valid && exp_er)
            q.push_back('{evt_address, evt_error, cyc});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_lkp_ready();
      int n = 0;
      while (!lkp_ready && n < 50) begin
         step();
         n++;
      end
      if (!lkp_ready) chk("lkp_ready_tmo", 0, 1);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         step();
         n++;
      end
      if (!rsp_valid) chk("rsp_tmo", 0, 1);
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_evt_ready", evt_ready, 1);
      chk("rst_lkp_ready", lkp_ready, 1);
      chk("rst_count", evt_count, 0);
      chk("rst_we", write_enable, 0);
      chk("rst_rv", rsp_valid, 0);

      // Single event into an empty FIFO.
      evt_valid   = 1'b1;
      evt_address = 32'hAABBCCDD;
      evt_error   = 10'b1010101010;
      step();
      evt_valid = 1'b0;
      chk("t1_we", write_enable, 1);
      chk("t1_addr", write_address, 32'hAABBCCDD);
      chk("t1_err", write_error, 10'b1010101010);
      step();
      chk("t1_count", evt_count, 1);
      chk("t1_hold", write_address, 32'hAABBCCDD);

      // Six back-to-back events.
      for (int i = 0; i < 6; i++) begin
         evt_valid   = 1'b1;
         evt_address = 32'h40 + 32'(i);
         evt_error   = 10'($urandom);
         chk("burst_ready", evt_ready, 1);
         step();
      end
      evt_valid = 1'b0;
      repeat (3) step();
      chk("burst_count", evt_count, 7);

      // Lookup of a freshly written address.
      evt_valid   = 1'b1;
      evt_address = 32'h12345678;
      evt_error   = 10'b1110001110;
      step();
      evt_valid = 1'b0;
      wait_lkp_ready();
      lkp_valid   = 1'b1;
      lkp_address = 32'h12345678;
      rsp_ready   = 1'b1;
      step();
      lkp_valid = 1'b0;
      step();
      chk("lk1_rv_early", rsp_valid, 0);
      step();
      chk("lk1_rv", rsp_valid, 1);
      chk("lk1_err", rsp_error, 10'b1110001110);
      step();

      // Lookup of an unwritten address with a stalled response.
      wait_lkp_ready();
      lkp_valid   = 1'b1;
      lkp_address = 32'hDEADBEEF;
      rsp_ready   = 1'b0;
      step();
      lkp_valid = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 5; i++) begin
         chk("lk2_rv", rsp_valid, 1);
         chk("lk2_err", rsp_error, 0);
         chk("lk2_lr", lkp_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("lk2_back", lkp_ready, 1);

      // Lookup waits behind two queued events and sees the newer one.
      evt_valid   = 1'b1;
      evt_address = 32'h77;
      evt_error   = 10'h11;
      step();
      evt_error   = 10'h22;
      lkp_valid   = 1'b1;
      lkp_address = 32'h77;
      chk("lk3_blk0", lkp_ready, 0);
      step();
      evt_valid = 1'b0;
      chk("lk3_blk1", lkp_ready, 0);
      step();
      chk("lk3_go", lkp_ready, 1);
      step();
      lkp_valid = 1'b0;
      wait_rsp();
      chk("lk3_err", rsp_error, 10'h22);
      step();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         evt_valid   = ($urandom_range(0, 2) != 0);
         evt_address = 32'h100 + 32'(4 * $urandom_range(0, 7));
         evt_error   = 10'($urandom);
         if (lkp_valid && lkp_hs) lkp_valid = 1'b0;
         if (!lkp_valid && $urandom_range(0, 5) == 0) begin
            lkp_valid   = 1'b1;
            lkp_address = 32'h100 + 32'(4 * $urandom_range(0, 8));
         end
         rsp_ready = 1'($urandom_range(0, 1));
         step();
      end
      evt_valid = 1'b0;
      if (lkp_valid && lkp_hs) lkp_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (8) step();
      lkp_valid = 1'b0;
      repeat (8) step();

      // Reset while a response is pending and events stream in.
      wait_lkp_ready();
      lkp_valid   = 1'b1;
      lkp_address = 32'h104;
      rsp_ready   = 1'b0;
      step();
      lkp_valid   = 1'b0;
      evt_valid   = 1'b1;
      evt_address = 32'h200;
      step();
      evt_address = 32'h204;
      step();
      chk("r_in_resp", rsp_valid, 1);
      #2;
      rst_n     = 1'b0;
      evt_valid = 1'b0;
      #1;
      chk("r_we", write_enable, 0);
      chk("r_waddr", write_address, 0);
      chk("r_werr", write_error, 0);
      chk("r_re", read_enable, 0);
      chk("r_raddr", read_address, 0);
      chk("r_rv", rsp_valid, 0);
      chk("r_rerr", rsp_error, 0);
      chk("r_count", evt_count, 0);
      repeat (2) step();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      step();
      chk("r_evt_ready", evt_ready, 1);
      chk("r_lkp_ready", lkp_ready, 1);
      for (int i = 0; i < 5; i++) begin
         chk("r_no_we", write_enable, 0);
         chk("r_no_rv", rsp_valid, 0);
         step();
      end
      chk("r_count_end", evt_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
